// File: rtl/rename_register_file.sv
// Architectural register file with per-register rename tags: issue marks rd pending on a RoB id,
// commit writes the retired value and releases the tag if it still matches.
module rename_register_file #(
  parameter int unsigned BITS    = 4,
  parameter int unsigned REG_NUM = 32
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rdy_in,
  input  logic            clear_in,
  input  logic [4:0]      issue_rd,
  input  logic [BITS-1:0] issue_tag,
  input  logic [4:0]      commit_rd,
  input  logic [31:0]     commit_value,
  input  logic [4:0]      release_rd,
  input  logic [BITS-1:0] release_tag,
  input  logic [4:0]      rs1_id,
  output logic            rs1_busy,
  output logic [BITS-1:0] rs1_tag,
  output logic [31:0]     rs1_value,
  input  logic [4:0]      rs2_id,
  output logic            rs2_busy,
  output logic [BITS-1:0] rs2_tag,
  output logic [31:0]     rs2_value
);

  logic [31:0]     value_q [REG_NUM];
  logic            busy_q  [REG_NUM];
  logic [BITS-1:0] tag_q   [REG_NUM];

  // Entry 0 is only ever reset, so x0 reads as zero and is never renamed.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int unsigned r = 0; r < REG_NUM; r++) begin
        value_q[r] <= '0;
        busy_q[r]  <= 1'b0;
        tag_q[r]   <= '0;
      end
    end else if (rdy_in) begin
      for (int unsigned r = 1; r < REG_NUM; r++) begin
        if (commit_rd == 5'(r)) begin
          value_q[r] <= commit_value;
        end
        if (clear_in) begin
          busy_q[r] <= 1'b0;
        end else if (issue_rd == 5'(r)) begin
          busy_q[r] <= 1'b1;
          tag_q[r]  <= issue_tag;
        end else if (release_rd == 5'(r) && busy_q[r] && tag_q[r] == release_tag) begin
          busy_q[r] <= 1'b0;
        end
      end
    end
  end

  logic [4:0]      rd_id    [2];
  logic            rd_busy  [2];
  logic [BITS-1:0] rd_tag   [2];
  logic [31:0]     rd_value [2];

  assign rd_id[0] = rs1_id;
  assign rd_id[1] = rs2_id;

  // Commit and release bypass to the readers; issue and clear do not.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_busy[p]  = 1'b0;
      rd_tag[p]   = '0;
      rd_value[p] = '0;
      if (rd_id[p] != 5'd0) begin
        rd_busy[p]  = busy_q[rd_id[p]];
        rd_tag[p]   = tag_q[rd_id[p]];
        rd_value[p] = value_q[rd_id[p]];
        if (rdy_in) begin
          if (commit_rd == rd_id[p]) begin
            rd_value[p] = commit_value;
          end
          if (release_rd == rd_id[p] && busy_q[rd_id[p]] && tag_q[rd_id[p]] == release_tag) begin
            rd_busy[p] = 1'b0;
          end
        end
      end
    end
  end

  assign rs1_busy  = rd_busy[0];
  assign rs1_tag   = rd_tag[0];
  assign rs1_value = rd_value[0];
  assign rs2_busy  = rd_busy[1];
  assign rs2_tag   = rd_tag[1];
  assign rs2_value = rd_value[1];

endmodule
